// File: rtl/br_write_sched.sv
// Write-port scheduler for the br register bank: round-robin between ALU (A) and load (B)
// writebacks, plus a clear sequence that zeroes all registers. Option macro: BR_ZERO_REG_EN.
module br_write_sched #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              init_start,
    output logic              busy,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite
);

    typedef enum logic {INIT, ARB} state_t;

    localparam logic              RR_A      = 1'b0;
    localparam logic              RR_B      = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              rr_ptr_q;
    logic              busy_q;
    logic              regwrite_q;
    logic [ADDR_W-1:0] writereg_q;
    logic [DATA_W-1:0] writedata_q;

    logic              rr_ptr_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_data_d;
    logic              xfer_a;
    logic              xfer_b;
    logic              zero_blocked;

    always_comb begin
        a_ready = (state_q == ARB) && !init_start && a_valid && (!b_valid || rr_ptr_q == RR_A);
        b_ready = (state_q == ARB) && !init_start && b_valid && (!a_valid || rr_ptr_q == RR_B);
        xfer_a  = a_valid && a_ready;
        xfer_b  = b_valid && b_ready;

        sel_addr_d = xfer_b ? b_addr : a_addr;
        sel_data_d = xfer_b ? b_data : a_data;

        // Only a contested grant moves the pointer; a lone requester leaves it alone.
        rr_ptr_d = rr_ptr_q;
        if ((xfer_a || xfer_b) && a_valid && b_valid)
            rr_ptr_d = xfer_a ? RR_B : RR_A;

        wr_en_d = (xfer_a || xfer_b) && !zero_blocked;
    end

`ifdef BR_ZERO_REG_EN
    // Writes to register 0 are accepted but dropped so it always reads as zero.
    assign zero_blocked = (sel_addr_d == '0);
`else
    assign zero_blocked = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rr_ptr_q    <= RR_A;
            busy_q      <= 1'b1;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    regwrite_q  <= 1'b1;
                    writereg_q  <= cnt_q;
                    writedata_q <= '0;
                    cnt_q       <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ARB;
                        busy_q  <= 1'b0;
                    end
                end
                ARB: begin
                    if (init_start) begin
                        state_q    <= INIT;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        regwrite_q <= 1'b0;
                    end else begin
                        rr_ptr_q   <= rr_ptr_d;
                        regwrite_q <= wr_en_d;
                        if (wr_en_d) begin
                            writereg_q  <= sel_addr_d;
                            writedata_q <= sel_data_d;
                        end
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign busy      = busy_q;
    assign RegWrite  = regwrite_q;
    assign WriteReg  = writereg_q;
    assign WriteData = writedata_q;

endmodule

// File: tb/tb_br_write_sched.sv
// Directed bench for br_write_sched: clear sequence, single/dual requesters, init_start
// interaction, mid-clear reset and the address-0 write behaviour.
module tb_br_write_sched;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_valid, b_valid, init_start;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready, busy, RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;

    int n_cmp = 0;
    int n_err = 0;

    br_write_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .init_start(init_start), .busy(busy),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [4:0] addr, input logic [31:0] data);
        chk({tag, ".RegWrite"}, {31'd0, RegWrite}, 32'd1);
        chk({tag, ".WriteReg"}, {27'd0, WriteReg}, {27'd0, addr});
        chk({tag, ".WriteData"}, WriteData, data);
        $display("write %s: reg=%0d data=%0h", tag, WriteReg, WriteData);
    endtask

    initial begin
        reset = 1'b1; a_valid = 0; b_valid = 0; init_start = 0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;

        // 1. Reset for 3 cycles, then the 32-cycle clear
        repeat (3) @(posedge clk);
        #1;
        a_valid = 1; b_valid = 1; a_addr = 5'd3; b_addr = 5'd4;
        #1;
        chk("rst.RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("rst.WriteReg", {27'd0, WriteReg}, 32'd0);
        chk("rst.WriteData", WriteData, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd1);
        chk("rst.a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst.b_ready", {31'd0, b_ready}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk_write("clear", 5'(i), 32'd0);
            chk("clear.busy", {31'd0, busy}, (i < 31) ? 32'd1 : 32'd0);
            chk("clear.a_ready", {31'd0, a_ready}, 32'd0);
            chk("clear.b_ready", {31'd0, b_ready}, 32'd0);
            if (i == 10) init_start = 1;   // ignored during INIT
            if (i == 11) init_start = 0;
            if (i == 30) begin a_valid = 0; b_valid = 0; end
        end

        // 2. Lone A write
        a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        chk("lone.a_ready", {31'd0, a_ready}, 32'd1);
        chk("lone.b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        chk_write("loneA", 5'd5, 32'hDEADBEEF);
        a_valid = 0;
        tick();
        chk("idle.RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("idle.WriteReg", {27'd0, WriteReg}, 32'd5);
        chk("idle.WriteData", WriteData, 32'hDEADBEEF);

        // 3. Both valid for 4 cycles: A,B,A,B
        a_valid = 1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1; b_addr = 5'd2; b_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr.a_ready", {31'd0, a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr.b_ready", {31'd0, b_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            if (k % 2 == 0) chk_write("rrA", 5'd1, 32'h11);
            else            chk_write("rrB", 5'd2, 32'h22);
        end
        // Lone B must not move the pointer (still A)
        a_valid = 0; b_addr = 5'd9; b_data = 32'h99;
        #1;
        chk("loneB.b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        chk_write("loneB", 5'd9, 32'h99);
        a_valid = 1; a_addr = 5'd12; a_data = 32'hC0;
        #1;
        chk("ptrA.a_ready", {31'd0, a_ready}, 32'd1);
        chk("ptrA.b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        chk_write("ptrA", 5'd12, 32'hC0);   // pointer now at B

        // 4. init_start with both pending: INIT wins, pointer survives
        a_addr = 5'd6; a_data = 32'h66; b_addr = 5'd7; b_data = 32'h77;
        init_start = 1;
        #1;
        chk("init.a_ready", {31'd0, a_ready}, 32'd0);
        chk("init.b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        init_start = 0;
        chk("init.RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("init.busy", {31'd0, busy}, 32'd1);
        for (int j = 0; j < 32; j++) begin
            chk("init2.a_ready", {31'd0, a_ready}, 32'd0);
            tick();
            chk_write("reclear", 5'(j), 32'd0);
        end
        chk("post.busy", {31'd0, busy}, 32'd0);
        chk("post.a_ready", {31'd0, a_ready}, 32'd0);
        chk("post.b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        chk_write("postB", 5'd7, 32'h77);
        b_valid = 0;
        #1;
        chk("post2.a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        chk_write("postA", 5'd6, 32'h66);
        a_valid = 0;

        // 5. Reset at INIT cnt=10
        init_start = 1;
        tick();
        init_start = 0;
        for (int j = 0; j < 10; j++) tick();
        chk_write("preRst", 5'd9, 32'd0);
        a_valid = 1; a_addr = 5'd3;
        reset = 1;
        #1;
        chk("mid.RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("mid.WriteReg", {27'd0, WriteReg}, 32'd0);
        chk("mid.busy", {31'd0, busy}, 32'd1);
        chk("mid.a_ready", {31'd0, a_ready}, 32'd0);
        tick();
        reset = 0;
        a_valid = 0;
        for (int j = 0; j < 32; j++) begin
            tick();
            chk_write("restart", 5'(j), 32'd0);
        end

        // 6. Write to address 0
        a_valid = 1; a_addr = 5'd0; a_data = 32'd7;
        #1;
        chk("zero.a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 0;
`ifdef BR_ZERO_REG_EN
        chk("zero.RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("zero.WriteReg", {27'd0, WriteReg}, 32'd31);
`else
        chk_write("zero", 5'd0, 32'd7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
